ts_packet_transmitter: RTL
==========================

Name: ts_packet_transmitter

Overview:
- Transmit-side counterpart of the TS input path.
- Pulls one 188-byte MPEG-TS packet from an upstream packet buffer into an internal packet RAM, checks the sync byte, then replays the packet as a byte-parallel TS stream: DATA, DCLK, D_VALID, P_SYNC.
- Feeds the modulator/loopback port; all logic runs on SYS_CLK, and DCLK_OUT is generated internally.

Parameters:
- PKT_LEN, 188, bytes per packet (max 255).
- CLK_DIV, 4, SYS_CLK cycles per output byte; even, >=2.
- GAP_BYTES, 0, idle byte periods (D_VALID low) inserted after each packet (0..255).
- SYNC_BYTE, 8'h47, required value of packet byte 0.
- LOAD_TIMEOUT, 1023, max SYS_CLK cycles between IN_VALID bytes during load.

Ports:
- SYS_CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- PACKET_READY  in  1  upstream holds >= PKT_LEN bytes.
- IN_DATA  in  8  packet byte from upstream.
- IN_VALID  in  1  IN_DATA qualifier.
- GIVE_ME_ONE_PACKET  out  1  one-cycle request pulse to upstream.
- DATA_OUT  out  8  TS byte.
- DCLK_OUT  out  1  TS byte clock, continuous.
- D_VALID  out  1  byte valid.
- P_SYNC  out  1  high during packet byte 0.
- BUSY  out  1  high in every state except IDLE.
- SYNC_ERR  out  1  one-cycle pulse: packet dropped, bad sync byte.
- TIMEOUT_ERR  out  1  one-cycle pulse: load aborted.

Behaviour:
- Reset (async, RST low): all outputs 0; state IDLE; divider, byte index and timeout counters 0. Reset mid-packet truncates the output immediately (D_VALID=0 asynchronously). The partial packet is lost and is not resumed.
- Divider: div_cnt counts 0..CLK_DIV-1 freely from reset.
  - DCLK_OUT is registered: 0 while div_cnt < CLK_DIV/2, else 1.
  - A byte boundary is the cycle with div_cnt==0.
  - DATA_OUT, D_VALID and P_SYNC change only at boundaries, i.e. on DCLK falling edges. They are stable across the rising edge.
- State IDLE:
  - If PACKET_READY=1: assert GIVE_ME_ONE_PACKET for exactly 1 cycle, go to LOAD, clear the write index.
  - At boundaries while in IDLE: D_VALID=0, P_SYNC=0, DATA_OUT=0.
- State LOAD:
  - Each IN_VALID=1 cycle writes IN_DATA to buf[wr_idx] and increments wr_idx. The timeout counter clears on each IN_VALID.
  - IN_VALID outside LOAD is ignored.
  - On the PKT_LEN-th byte:
    - If buf[0] != SYNC_BYTE: pulse SYNC_ERR on the next cycle and return to IDLE. Nothing is transmitted.
    - Otherwise go to WAIT_BND.
  - If the timeout counter reaches LOAD_TIMEOUT: pulse TIMEOUT_ERR and return to IDLE.
- State WAIT_BND: wait for the next boundary, then enter SEND with rd_idx=0.
- State SEND, at each boundary:
  - DATA_OUT=buf[rd_idx]; D_VALID=1; P_SYNC=(rd_idx==0); rd_idx increments.
  - At the boundary after rd_idx reached PKT_LEN:
    - If GAP_BYTES>0: go to GAP and drive D_VALID=0, P_SYNC=0, DATA_OUT=0.
    - Otherwise go to IDLE with the same output values.
- State GAP: count GAP_BYTES boundaries, then go to IDLE. PACKET_READY is not sampled in GAP or SEND.
- Packet duration: exactly PKT_LEN*CLK_DIV SYS_CLK cycles of D_VALID=1.
- Latency: SYNC_BYTE appears on DATA_OUT (with P_SYNC) at the first boundary after the last load byte, i.e. <= CLK_DIV cycles later.
- Back-to-back packets always have a gap of at least the next load time; this is accepted.
- Simultaneous events:
  - A timeout and the final byte in the same cycle: the byte wins.
  - PACKET_READY high on the same cycle SEND/GAP exits to IDLE: the request is issued on the following cycle.
- Widths:
  - wr_idx and rd_idx are 8 bits.
  - The timeout counter is wide enough for LOAD_TIMEOUT and saturates.
  - The divider is ceil(log2(CLK_DIV)) bits.

Test Plan:
- Reset, PACKET_READY=0 for 100 cycles -> all outputs 0 except DCLK_OUT toggling with period 4; BUSY=0.
- PACKET_READY=1; feed 188 bytes 0x47,0x01..0xBB with IN_VALID continuous -> exactly one request pulse. Then 188 D_VALID byte periods of 4 cycles each: first DATA_OUT=0x47 with P_SYNC=1 for one byte only, last byte 0xBB. BUSY falls after the final period.
- Same stimulus with byte 0 = 0x00 -> SYNC_ERR pulses once, D_VALID never asserts, BUSY returns to 0.
- Feed 100 bytes then stop IN_VALID -> TIMEOUT_ERR pulses 1023 cycles after byte 100; IDLE; the next PACKET_READY restarts a clean load.
- GAP_BYTES=3, two packets queued -> >= 3 D_VALID-low byte periods between packets. The second P_SYNC coincides with 0x47.
- Assert RST at SEND byte 50 -> D_VALID=0 immediately. After release: no residual bytes, a new request only when PACKET_READY=1.

Source files
------------

// File: rtl/ts_packet_transmitter_if.sv
// Packet-buffer pull handshake and byte-parallel TS output bundle.
// The slave side is the transmitter; the master side is the upstream buffer / sink.
interface ts_packet_transmitter_if;
  logic       PACKET_READY;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       GIVE_ME_ONE_PACKET;
  logic [7:0] DATA_OUT;
  logic       DCLK_OUT;
  logic       D_VALID;
  logic       P_SYNC;
  logic       BUSY;
  logic       SYNC_ERR;
  logic       TIMEOUT_ERR;

  modport master (
    output PACKET_READY, IN_DATA, IN_VALID,
    input  GIVE_ME_ONE_PACKET, DATA_OUT, DCLK_OUT, D_VALID, P_SYNC,
           BUSY, SYNC_ERR, TIMEOUT_ERR
  );

  modport slave (
    input  PACKET_READY, IN_DATA, IN_VALID,
    output GIVE_ME_ONE_PACKET, DATA_OUT, DCLK_OUT, D_VALID, P_SYNC,
           BUSY, SYNC_ERR, TIMEOUT_ERR
  );
endinterface

// File: rtl/ts_packet_transmitter.sv
// Pulls one TS packet from upstream into a local RAM, checks the sync byte,
// then replays it as a byte-parallel stream clocked by an internal DCLK.
module ts_packet_transmitter #(
  parameter int         PKT_LEN      = 188,
  parameter int         CLK_DIV      = 4,
  parameter int         GAP_BYTES    = 0,
  parameter logic [7:0] SYNC_BYTE    = 8'h47,
  parameter int         LOAD_TIMEOUT = 1023
) (
  input  logic                   SYS_CLK,
  input  logic                   RST,
  ts_packet_transmitter_if.slave ts
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);
  localparam logic [7:0]       LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0]       PKT_END  = 8'(PKT_LEN);
  localparam logic [7:0]       GAP_LAST = (GAP_BYTES > 0) ? 8'(GAP_BYTES - 1) : 8'd0;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BND, SEND, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             bnd;
  logic [7:0]       wr_idx;
  logic [7:0]       rd_idx;
  logic [7:0]       gap_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             sync_ok;
  logic             last_byte_ok;
  logic [7:0]       pkt_ram [PKT_LEN];

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // bnd marks the edge that opens a new byte period (div_cnt wraps to 0, DCLK falls)
  assign bnd     = (div_cnt == DIV_LAST);
  assign div_nxt = bnd ? '0 : div_cnt + 1'b1;
  // byte 0 may be arriving this very cycle when the packet is one byte long
  assign last_byte_ok = (wr_idx == 8'd0) ? (ts.IN_DATA == SYNC_BYTE) : sync_ok;

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      div_cnt     <= '0;
      ts.DCLK_OUT <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      ts.DCLK_OUT <= (div_nxt >= DIV_HALF);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (state == LOAD && ts.IN_VALID)
      pkt_ram[wr_idx] <= ts.IN_DATA;
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state                 <= IDLE;
      wr_idx                <= '0;
      rd_idx                <= '0;
      gap_cnt               <= '0;
      tmo_cnt               <= '0;
      sync_ok               <= 1'b0;
      ts.GIVE_ME_ONE_PACKET <= 1'b0;
      ts.DATA_OUT           <= '0;
      ts.D_VALID            <= 1'b0;
      ts.P_SYNC             <= 1'b0;
      ts.BUSY               <= 1'b0;
      ts.SYNC_ERR           <= 1'b0;
      ts.TIMEOUT_ERR        <= 1'b0;
    end else begin
      ts.GIVE_ME_ONE_PACKET <= 1'b0;
      ts.SYNC_ERR           <= 1'b0;
      ts.TIMEOUT_ERR        <= 1'b0;
      case (state)
        IDLE: begin
          if (bnd) begin
            ts.DATA_OUT <= '0;
            ts.D_VALID  <= 1'b0;
            ts.P_SYNC   <= 1'b0;
          end
          if (ts.PACKET_READY) begin
            ts.GIVE_ME_ONE_PACKET <= 1'b1;
            ts.BUSY               <= 1'b1;
            wr_idx                <= '0;
            tmo_cnt               <= '0;
            state                 <= LOAD;
          end
        end
        LOAD: begin
          // an arriving byte takes priority over an expiring timeout
          if (ts.IN_VALID) begin
            wr_idx  <= wr_idx + 8'd1;
            tmo_cnt <= '0;
            if (wr_idx == 8'd0)
              sync_ok <= (ts.IN_DATA == SYNC_BYTE);
            if (wr_idx == LAST_IDX) begin
              if (last_byte_ok) begin
                state <= WAIT_BND;
              end else begin
                ts.SYNC_ERR <= 1'b1;
                ts.BUSY     <= 1'b0;
                state       <= IDLE;
              end
            end
          end else if (tmo_cnt >= TMO_LAST) begin
            ts.TIMEOUT_ERR <= 1'b1;
            ts.BUSY        <= 1'b0;
            state          <= IDLE;
          end else begin
            tmo_cnt <= sat_inc(tmo_cnt);
          end
        end
        WAIT_BND: begin
          if (bnd) begin
            ts.DATA_OUT <= pkt_ram[0];
            ts.D_VALID  <= 1'b1;
            ts.P_SYNC   <= 1'b1;
            rd_idx      <= 8'd1;
            state       <= SEND;
          end
        end
        SEND: begin
          if (bnd) begin
            if (rd_idx == PKT_END) begin
              ts.DATA_OUT <= '0;
              ts.D_VALID  <= 1'b0;
              ts.P_SYNC   <= 1'b0;
              if (GAP_BYTES > 0) begin
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                ts.BUSY <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              ts.DATA_OUT <= pkt_ram[rd_idx];
              ts.P_SYNC   <= 1'b0;
              rd_idx      <= rd_idx + 8'd1;
            end
          end
        end
        GAP: begin
          if (bnd) begin
            if (gap_cnt == GAP_LAST) begin
              ts.BUSY <= 1'b0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
